// File: rtl/rom_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rom_port_arbiter
// Brief   : Shares one synchronous instruction ROM between CPU fetch and a
//           debug/loader read port, CPU first with bounded debug starvation.
// Revision: 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DBG_ACK  = 2'd1,
    ST_DBG_DROP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0]  cpu_data_q, cpu_data_d;
  logic [DATA_W-1:0]  dbg_data_q, dbg_data_d;

  logic idle;
  logic dbg_win;
  logic cpu_win;

  always_comb begin
    idle    = (state_q == ST_IDLE);
    // Grants are masked while reset is held so the ROM side stays quiet.
    dbg_win = rst & idle & dbg_req_i & (~cpu_ce_i | (starve_cnt_q == CNT_MAX));
    cpu_win = rst & cpu_ce_i & ~dbg_win;

    rom_ce_o    = dbg_win | cpu_win;
    rom_addr_o  = '0;
    if (dbg_win) begin
      rom_addr_o = dbg_addr_i;
    end else if (cpu_win) begin
      rom_addr_o = cpu_addr_i;
    end
    cpu_stall_o = cpu_ce_i & dbg_win;

    owner_d = OWN_NONE;
    if (dbg_win) begin
      owner_d = OWN_DBG;
    end else if (cpu_win) begin
      owner_d = OWN_CPU;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (dbg_win) state_d = ST_DBG_ACK;
      ST_DBG_ACK:  state_d = ST_DBG_DROP;
      ST_DBG_DROP: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    starve_cnt_d = starve_cnt_q;
    if (dbg_win) begin
      starve_cnt_d = '0;
    end else if (idle & ~dbg_req_i) begin
      starve_cnt_d = '0;
    end else if (idle & cpu_win & (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    cpu_data_o = (owner_q == OWN_CPU) ? rom_data_i : cpu_data_q;
    cpu_data_d = cpu_data_o;
    dbg_ack_o  = (owner_q == OWN_DBG);
    dbg_data_o = dbg_ack_o ? rom_data_i : dbg_data_q;
    dbg_data_d = dbg_data_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
      cpu_data_q   <= '0;
      dbg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_data_q   <= cpu_data_d;
      dbg_data_q   <= dbg_data_d;
    end
  end

endmodule
`default_nettype wire
